// File: rtl/tt_um_hoene_manchester_pkg.sv
// Shared definitions for the Manchester frame controller: FSM states,
// abort cause codes and a small counter helper.
package tt_um_hoene_manchester_pkg;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        LEN  = 2'd1,
        DATA = 2'd2,
        CHK  = 2'd3
    } frame_state_t;

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_BIT      = 3'd1;
    localparam logic [2:0] ERR_TIMEOUT  = 3'd2;
    localparam logic [2:0] ERR_LENGTH   = 3'd3;
    localparam logic [2:0] ERR_CHECKSUM = 3'd4;
    localparam logic [2:0] ERR_OVERFLOW = 3'd5;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/tt_um_hoene_manchester_byte_assembler.sv
// MSB-first bit shifter with a modulo-8 bit counter; byte_next is the value
// the register takes on this strobe, done flags the 8th strobe of a byte.
module tt_um_hoene_manchester_byte_assembler (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       bit_strobe,
    input  logic       bit_data,
    output logic [7:0] byte_next,
    output logic       done
);

    logic [7:0] shift_reg;
    logic [2:0] bit_count;

    assign byte_next = {shift_reg[6:0], bit_data};
    assign done      = bit_strobe && (bit_count == 3'd7);

    // clear wins over a same-cycle strobe: that bit is consumed by the caller
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= 8'd0;
            bit_count <= 3'd0;
        end else if (clear) begin
            shift_reg <= 8'd0;
            bit_count <= 3'd0;
        end else if (bit_strobe) begin
            shift_reg <= byte_next;
            bit_count <= bit_count + 3'd1;
        end
    end

endmodule

// File: rtl/tt_um_hoene_manchester_frame_ctrl.sv
// Frame controller: hunts for the sync word, reads length, payload and XOR
// checksum, hands payload bytes to a ready/valid sink and reports aborts.
module tt_um_hoene_manchester_frame_ctrl
    import tt_um_hoene_manchester_pkg::*;
#(
    parameter logic [7:0]  SYNC_WORD = 8'hA5,
    parameter int          MAX_LEN   = 16,
    parameter logic [15:0] TIMEOUT   = 16'd1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       bit_data,
    input  logic       bit_strobe,
    input  logic       bit_error,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    input  logic       byte_ready,
    output logic       frame_start,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [2:0] err_code
);

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    frame_state_t state;
    logic [7:0]   checksum;
    logic [7:0]   remaining;
    logic [15:0]  idle_cnt;

    logic [7:0]   asm_byte;
    logic         asm_done;
    logic         asm_clear;
    logic         in_frame;
    logic         sync_hit;
    logic         timeout_hit;
    logic         byte_done;
    logic         sink_full;
    logic         frame_end;

    always_comb begin
        in_frame    = (state != HUNT);
        sink_full   = byte_valid && !byte_ready;
        sync_hit    = !in_frame && bit_strobe && !bit_error && (asm_byte == SYNC_WORD);
        timeout_hit = in_frame && !bit_error && (idle_cnt >= TIMEOUT);
        byte_done   = in_frame && !bit_error && !timeout_hit && asm_done;
        frame_end   = byte_done && ((state == CHK) ||
                                    ((state == LEN) && (asm_byte > MAX_LEN_B)) ||
                                    ((state == DATA) && sink_full));
        // bit_error clears the shifter both while hunting and as an abort
        asm_clear   = sync_hit || bit_error || timeout_hit || frame_end;
    end

    tt_um_hoene_manchester_byte_assembler u_assembler (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (asm_clear),
        .bit_strobe (bit_strobe),
        .bit_data   (bit_data),
        .byte_next  (asm_byte),
        .done       (asm_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= 16'd0;
        end else if (bit_strobe) begin
            idle_cnt <= 16'd0;
        end else begin
            idle_cnt <= sat_inc16(idle_cnt);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= HUNT;
            checksum    <= 8'd0;
            remaining   <= 8'd0;
            byte_data   <= 8'd0;
            byte_valid  <= 1'b0;
            frame_start <= 1'b0;
            frame_ok    <= 1'b0;
            frame_err   <= 1'b0;
            err_code    <= ERR_NONE;
        end else begin
            frame_start <= 1'b0;
            frame_ok    <= 1'b0;
            frame_err   <= 1'b0;
            if (byte_valid && byte_ready) begin
                byte_valid <= 1'b0;
            end

            if (!in_frame) begin
                if (sync_hit) begin
                    state       <= LEN;
                    checksum    <= 8'd0;
                    err_code    <= ERR_NONE;
                    frame_start <= 1'b1;
                end
            end else if (bit_error) begin
                state     <= HUNT;
                frame_err <= 1'b1;
                err_code  <= ERR_BIT;
            end else if (timeout_hit) begin
                state     <= HUNT;
                frame_err <= 1'b1;
                err_code  <= ERR_TIMEOUT;
            end else if (asm_done) begin
                case (state)
                    LEN: begin
                        checksum  <= asm_byte;
                        remaining <= asm_byte;
                        if (asm_byte == 8'd0) begin
                            state <= CHK;
                        end else if (asm_byte > MAX_LEN_B) begin
                            state     <= HUNT;
                            frame_err <= 1'b1;
                            err_code  <= ERR_LENGTH;
                        end else begin
                            state <= DATA;
                        end
                    end
                    DATA: begin
                        // a still-unconsumed byte is never overwritten
                        if (sink_full) begin
                            state     <= HUNT;
                            frame_err <= 1'b1;
                            err_code  <= ERR_OVERFLOW;
                        end else begin
                            byte_data  <= asm_byte;
                            byte_valid <= 1'b1;
                            checksum   <= checksum ^ asm_byte;
                            remaining  <= remaining - 8'd1;
                            if (remaining == 8'd1) begin
                                state <= CHK;
                            end
                        end
                    end
                    CHK: begin
                        state <= HUNT;
                        if (asm_byte == checksum) begin
                            frame_ok <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                            err_code  <= ERR_CHECKSUM;
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tt_um_hoene_manchester_frame_ctrl.sv
// Bench for the Manchester frame controller: directed frames plus random
// frames checked against a frame-level model of delivered bytes and outcome.
module tb_tt_um_hoene_manchester_frame_ctrl;

    localparam int MAX_LEN = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       bit_data = 1'b0;
    logic       bit_strobe = 1'b0;
    logic       bit_error = 1'b0;
    logic       byte_ready = 1'b1;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       frame_start;
    logic       frame_ok;
    logic       frame_err;
    logic [2:0] err_code;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    tt_um_hoene_manchester_frame_ctrl #(
        .SYNC_WORD (8'hA5),
        .MAX_LEN   (MAX_LEN),
        .TIMEOUT   (16'd1000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bit_data    (bit_data),
        .bit_strobe  (bit_strobe),
        .bit_error   (bit_error),
        .byte_data   (byte_data),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .frame_start (frame_start),
        .frame_ok    (frame_ok),
        .frame_err   (frame_err),
        .err_code    (err_code)
    );

    // observed events, sampled on the falling edge
    logic [7:0] got_q[$];
    int         n_start, n_ok, n_err, n_both_total;
    logic [2:0] last_code;

    initial n_both_total = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (byte_valid && byte_ready) got_q.push_back(byte_data);
            if (frame_start) n_start++;
            if (frame_ok) n_ok++;
            if (frame_err) begin
                n_err++;
                last_code = err_code;
            end
            if (frame_ok && frame_err) n_both_total++;
        end
    end

    // reference model outputs
    logic [7:0] exp_q[$];
    int         exp_ok, exp_err;
    logic [2:0] exp_code;
    logic [7:0] pay[256];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        got_q.delete();
        n_start   = 0;
        n_ok      = 0;
        n_err     = 0;
        last_code = 3'd0;
    endtask

    // all stimulus tasks start and end 1 time unit after a rising edge
    task automatic send_bit(input logic b);
        bit_data   = b;
        bit_strobe = 1'b1;
        @(posedge clk);
        #1;
        bit_strobe = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        for (int i = 7; i >= 0; i--) begin
            send_bit(b[i]);
            if (i != 0) idle(gap);
        end
    endtask

    task automatic hunt_clear();
        bit_error = 1'b1;
        idle(1);
        bit_error = 1'b0;
    endtask

    // frame outcome from the protocol rules: XOR of length and payload
    task automatic model_frame(input logic [7:0] len, input logic [7:0] cbyte);
        logic [7:0] x;
        exp_q.delete();
        if (int'(len) > MAX_LEN) begin
            exp_ok = 0; exp_err = 1; exp_code = 3'd3;
        end else begin
            x = len;
            for (int i = 0; i < int'(len); i++) begin
                exp_q.push_back(pay[i]);
                x = x ^ pay[i];
            end
            if (cbyte == x) begin
                exp_ok = 1; exp_err = 0; exp_code = 3'd0;
            end else begin
                exp_ok = 0; exp_err = 1; exp_code = 3'd4;
            end
        end
    endtask

    task automatic compare_frame(input string tag);
        int n;
        check({tag, "_start"}, n_start, 1);
        check({tag, "_nbytes"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check({tag, "_byte"}, 32'(got_q[i]), 32'(exp_q[i]));
        check({tag, "_ok"}, n_ok, exp_ok);
        check({tag, "_err"}, n_err, exp_err);
        if (exp_err != 0) check({tag, "_code"}, 32'(last_code), 32'(exp_code));
    endtask

    task automatic send_frame(input logic [7:0] len, input logic [7:0] cbyte, input int gap);
        send_byte(8'hA5, gap);
        send_byte(len, gap);
        if (int'(len) <= MAX_LEN) begin
            for (int i = 0; i < int'(len); i++) send_byte(pay[i], gap);
            send_byte(cbyte, gap);
        end
        idle(3);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] len, x, cbyte;
        int         cyc;
        logic       seen;

        clear_mon();
        #12;
        check("reset_outputs", 32'({byte_data, byte_valid, frame_start, frame_ok, frame_err, err_code}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // good frame with exact latency checks
        clear_mon();
        pay[0] = 8'h11; pay[1] = 8'h22;
        send_byte(8'hA5, 0);
        check("good_start_lat", 32'(frame_start), 32'd1);
        send_byte(8'h02, 0);
        send_byte(8'h11, 0);
        check("good_b0_lat", 32'({byte_valid, byte_data}), 32'({1'b1, 8'h11}));
        send_byte(8'h22, 0);
        check("good_b1_lat", 32'({byte_valid, byte_data}), 32'({1'b1, 8'h22}));
        send_byte(8'h31, 0);
        check("good_ok_lat", 32'({frame_ok, frame_err}), 32'({1'b1, 1'b0}));
        idle(2);
        model_frame(8'h02, 8'h31);
        compare_frame("good");

        // bad checksum
        clear_mon();
        send_frame(8'h02, 8'h30, 0);
        model_frame(8'h02, 8'h30);
        compare_frame("badchk");
        check("badchk_errcode_port", 32'(err_code), 32'd4);

        // oversize length, then the next sync is found
        clear_mon();
        send_frame(8'h11, 8'h00, 0);
        model_frame(8'h11, 8'h00);
        compare_frame("len17");
        clear_mon();
        send_byte(8'hA5, 0);
        check("resync_start", 32'(frame_start), 32'd1);
        check("resync_code_cleared", 32'(err_code), 32'd0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        check("len0_ok", 32'(frame_ok), 32'd1);
        idle(2);

        // overflow with a stalled sink
        clear_mon();
        byte_ready = 1'b0;
        send_byte(8'hA5, 0);
        send_byte(8'h02, 0);
        send_byte(8'h11, 0);
        idle(2);
        send_byte(8'h22, 0);
        check("ovf_err", 32'({frame_err, err_code}), 32'({1'b1, 3'd5}));
        idle(1);
        check("ovf_hold", 32'({byte_valid, byte_data}), 32'({1'b1, 8'h11}));
        byte_ready = 1'b1;
        idle(1);
        check("ovf_drain", 32'(byte_valid), 32'd0);
        check("ovf_nbytes", got_q.size(), 1);
        idle(2);

        // bit_error while hunting clears the partial sync without an error
        clear_mon();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        hunt_clear();
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        idle(2);
        check("hunt_berr_nostart", n_start, 0);
        check("hunt_berr_noerr", n_err, 0);

        // bit_error inside a frame beats a same-cycle strobe
        hunt_clear();
        clear_mon();
        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        bit_error  = 1'b1;
        bit_strobe = 1'b1;
        idle(1);
        bit_error  = 1'b0;
        bit_strobe = 1'b0;
        check("frame_berr", 32'({frame_err, err_code}), 32'({1'b1, 3'd1}));
        idle(2);

        // random frames
        for (int f = 0; f < 12; f++) begin
            clear_mon();
            len = 8'($urandom_range(0, MAX_LEN + 4));
            if (f == 0) len = 8'(MAX_LEN);
            if (f == 1) len = 8'(MAX_LEN + 1);
            if (f == 2) len = 8'd0;
            x = len;
            for (int i = 0; i < MAX_LEN; i++) begin
                pay[i] = 8'($urandom_range(0, 255));
                if (i < int'(len)) x = x ^ pay[i];
            end
            cbyte = ($urandom_range(0, 3) == 0) ? (x ^ 8'($urandom_range(1, 255))) : x;
            send_frame(len, cbyte, $urandom_range(0, 2));
            model_frame(len, cbyte);
            compare_frame("rand");
        end

        // inter-strobe timeout
        clear_mon();
        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 1200) begin
            @(posedge clk);
            #1;
            cyc++;
            if (frame_err) seen = 1'b1;
        end
        check("timeout_seen", 32'(seen), 32'd1);
        check("timeout_window", 32'(cyc >= 995 && cyc <= 1005), 32'd1);
        check("timeout_code", 32'(err_code), 32'd2);
        idle(2);

        // asynchronous reset mid-frame with a held byte
        byte_ready = 1'b0;
        send_byte(8'hA5, 0);
        send_byte(8'h02, 0);
        send_byte(8'h11, 0);
        idle(1);
        check("pre_reset_valid", 32'(byte_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", 32'({byte_data, byte_valid, frame_start, frame_ok, frame_err, err_code}), 32'd0);
        byte_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        clear_mon();
        send_byte(8'hA5, 0);
        check("post_reset_start", 32'(frame_start), 32'd1);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        check("post_reset_ok", 32'(frame_ok), 32'd1);
        idle(2);

        check("ok_err_exclusive", n_both_total, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tt_um_hoene_manchester_frame_ctrl.md
TT_UM_HOENE_MANCHESTER_FRAME_CTRL -- requirements
Module: tt_um_hoene_manchester_frame_ctrl

Interface
REQ-001 SHALL have parameter SYNC_WORD, default 8'hA5: frame delimiter, MSB first.
REQ-002 SHALL have parameter MAX_LEN, default 16: largest accepted payload length in bytes (1..255).
REQ-003 SHALL have parameter TIMEOUT, default 16'd1000: maximum clk cycles between bit strobes inside a frame.
REQ-004 SHALL have port clk  input  1  single system clock; all logic on posedge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port bit_data  input  1  decoded bit from the Manchester decoder.
REQ-007 SHALL have port bit_strobe  input  1  one-cycle pulse; bit_data is valid on this cycle.
REQ-008 SHALL have port bit_error  input  1  decoder loss-of-sync level.
REQ-009 SHALL have port byte_data  output  8  received payload byte.
REQ-010 SHALL have port byte_valid  output  1  byte_data holds an unconsumed byte.
REQ-011 SHALL have port byte_ready  input  1  sink accepts byte when byte_valid && byte_ready.
REQ-012 SHALL have port frame_start  output  1  one-cycle pulse; sync word detected.
REQ-013 SHALL have port frame_ok  output  1  one-cycle pulse; checksum matched.
REQ-014 SHALL have port frame_err  output  1  one-cycle pulse; frame aborted.
REQ-015 SHALL have port err_code  output  3  cause of last frame_err; held until the next frame_start.

Function
REQ-016 SHALL use FSM states HUNT, LEN, DATA, CHK; bits are MSB first; each byte completes on its 8th bit_strobe.
REQ-017 In HUNT: shift every strobed bit into an 8-bit register; when the updated value equals SYNC_WORD, go to LEN, clear bit count and checksum, and pulse frame_start on the next cycle.
REQ-018 In HUNT: bit_error high clears the shift register; no frame_err is raised.
REQ-019 In LEN: on completion, length 0 goes to CHK; 1..MAX_LEN goes to DATA; >MAX_LEN aborts with err_code 3'd3. The length byte is not output.
REQ-020 In DATA: each completed byte is loaded into byte_data with byte_valid=1 on the next cycle (latency 1 clk); after length bytes, go to CHK.
REQ-021 Checksum SHALL be the 8-bit XOR of the length byte and all payload bytes; in CHK, the received byte equal to the checksum pulses frame_ok, otherwise aborts with err_code 3'd4; both cases return to HUNT.
REQ-022 byte_valid SHALL clear on the cycle after byte_valid && byte_ready, unless a new byte loads on that same cycle (it then stays 1 with the new data).
REQ-023 A DATA byte completing while byte_valid=1 and byte_ready=0 SHALL abort with err_code 3'd5 (overflow); the held byte stays valid and is not overwritten.
REQ-024 Idle counter: 16 bits, cleared on every bit_strobe, saturating; reaching TIMEOUT in LEN/DATA/CHK aborts with err_code 3'd2.
REQ-025 bit_error high in LEN/DATA/CHK SHALL abort with err_code 3'd1; it takes priority over a same-cycle strobe and over timeout.
REQ-026 Abort: frame_err pulses on the next cycle; the FSM returns to HUNT with the shift register cleared; an already-valid byte remains until consumed.
REQ-027 All pulse outputs SHALL be registered; frame_ok and frame_err SHALL never be high together.

Reset
REQ-028 While rst_n=0, state SHALL be HUNT and all registers and outputs 0 (err_code 3'd0), asynchronously, including mid-frame.
REQ-029 After rst_n deasserts, the first strobed bit SHALL be accepted into HUNT.

Structure
REQ-030 State encoding and err_code constants (0 none, 1 bit_error, 2 timeout, 3 length, 4 checksum, 5 overflow) SHALL live in package tt_um_hoene_manchester_pkg.
REQ-031 Bit shifting and bit counting SHALL be one sub-module, tt_um_hoene_manchester_byte_assembler (shift, count, done pulse, clear).

Verification
REQ-032 Send A5, 02, 11, 22, 31 with byte_ready=1 -> frame_start; bytes 11 and 22 each one cycle after their 8th strobe; frame_ok one cycle after the last strobe.
REQ-033 Send A5, 02, 11, 22, 30 -> bytes 11 and 22 delivered; then frame_err with err_code 4.
REQ-034 Send A5, 11 (MAX_LEN=16) -> frame_err with err_code 3; the next A5 is detected.
REQ-035 Send A5, 02, 11, hold byte_ready=0, send 22 -> frame_err with err_code 5; byte_data stays 11 and byte_valid stays 1.
REQ-036 After A5 01, send no strobes for 1000 cycles -> frame_err with err_code 2; assert rst_n=0 mid-frame -> all outputs 0 immediately.
